// File: rtl/i2s_rx_deserializer_if.sv
// Sample stream from the I2S receiver: head-of-buffer word with valid/ready plus event pulses.
interface i2s_rx_deserializer_if #(
  parameter int DATA_W = 23
);
  logic signed [DATA_W-1:0] sample_data;
  logic                     sample_right;
  logic                     sample_valid;
  logic                     sample_ready;
  logic                     overrun;
  logic                     short_word;

  modport master (
    output sample_data,
    output sample_right,
    output sample_valid,
    output overrun,
    output short_word,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_right,
    input  sample_valid,
    input  overrun,
    input  short_word,
    output sample_ready
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Oversampling Philips-I2S receiver: synchronises sck/ws/sd, rebuilds left/right PCM words
// and hands them out through a 2-entry valid/ready buffer.
module i2s_rx_deserializer #(
  parameter int DATA_W      = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  i2s_rx_deserializer_if.master smp
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  // Writes bit b at MSB-relative position cnt; positions past the LSB are dropped.
  function automatic logic [DATA_W-1:0] place_bit(input logic [DATA_W-1:0] w,
                                                  input logic b,
                                                  input logic [CNT_W-1:0] cnt);
    if (cnt < CNT_FULL) return w | (DATA_W'(b) << (LAST_POS - cnt));
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c < CNT_SAT) ? c + CNT_W'(1) : c;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_prev;
  logic                   edge_p0;
  logic                   ws_p0;
  logic                   sd_p0;

  state_t            state;
  logic              ws_last;
  logic              ws_known;
  logic              chan;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  logic [DATA_W:0]   mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              overrun_r;
  logic              short_r;

  logic              wr_req;
  logic              wr_ok;
  logic              rd;
  logic              word_short;
  logic [DATA_W-1:0] word_done;
  logic [DATA_W:0]   head;

  // Synchronizers and sck rise detection; edge_p0 qualifies the ws/sd captured with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
      edge_p0  <= 1'b0;
      ws_p0    <= 1'b0;
      sd_p0    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      edge_p0  <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
      ws_p0    <= ws_sync[SYNC_STAGES-1];
      sd_p0    <= sd_sync[SYNC_STAGES-1];
    end
  end

  // A ws change seen in SHIFT carries the LSB of the word in progress
  assign wr_req     = edge_p0 && (state == SHIFT) && (ws_p0 != ws_last);
  assign word_done  = place_bit(shreg, sd_p0, bit_cnt);
  assign word_short = bit_cnt < LAST_POS;

  // Word assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ws_last  <= 1'b0;
      ws_known <= 1'b0;
      chan     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else if (edge_p0) begin
      ws_last <= ws_p0;
      unique case (state)
        IDLE: begin
          ws_known <= 1'b1;
          if (ws_known && (ws_p0 != ws_last)) state <= ARM;
        end
        ARM: begin
          shreg   <= {sd_p0, {(DATA_W-1){1'b0}}};
          bit_cnt <= CNT_W'(1);
          chan    <= ws_p0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (ws_p0 != ws_last) begin
            state <= ARM;
          end else begin
            shreg   <= word_done;
            bit_cnt <= cnt_inc(bit_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd    = (count != 2'd0) && smp.sample_ready;
  assign wr_ok = wr_req && ((count != 2'd2) || rd);

  // Output buffer; a write into a full buffer succeeds only when the head leaves this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      overrun_r <= 1'b0;
      short_r   <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= {chan, word_done};
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) rd_ptr <= ~rd_ptr;
      case ({wr_ok, rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      overrun_r <= wr_req && !wr_ok;
      short_r   <= wr_ok && word_short;
    end
  end

  assign head             = mem[rd_ptr];
  assign smp.sample_data  = $signed(head[DATA_W-1:0]);
  assign smp.sample_right = head[DATA_W];
  assign smp.sample_valid = count != 2'd0;
  assign smp.overrun      = overrun_r;
  assign smp.short_word   = short_r;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives Philips-I2S half-frames and scoreboards the sample stream.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
  localparam int DATA_W = 23;

  logic clk = 1'b0;
  logic rst, sck, ws, sd;
  always #5 clk = ~clk;

  i2s_rx_deserializer_if #(.DATA_W(DATA_W)) bus ();

  i2s_rx_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd), .smp(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] got_q[$];
  int exp_short, exp_ovr, short_seen, ovr_seen, vld_cycles;
  bit mon_en = 0;
  bit chk_align = 0;
  int ready_mode = 0;
  int ph_min = 2, ph_max = 2;
  logic carry;
  logic [DATA_W:0] cur, prev_word;
  bit prev_stall, prev_short, prev_ovr;
  logic [DATA_W-1:0] rw;
  int rn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Receiver keeps the first n transmitted bits (MSB first), zero below them.
  function automatic logic [DATA_W-1:0] keep_msbs(input logic [DATA_W-1:0] w, input int n);
    logic [DATA_W-1:0] m;
    m = '1;
    if (n < DATA_W) m = m << (DATA_W - n);
    return w & m;
  endfunction

  function automatic logic tx_bit(input logic [DATA_W-1:0] w, input int i);
    if (i < DATA_W) return w[DATA_W-1-i];
    return 1'b0;
  endfunction

  // Consumer: ready changes 2 ns after the rising edge
  initial begin
    bus.sample_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.sample_ready = 1'b0;
        1:       bus.sample_ready = 1'b1;
        default: bus.sample_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {bus.sample_right, bus.sample_data};
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.sample_valid), 1);
        chk("hold_data", 32'(cur), 32'(prev_word));
      end
      if (bus.sample_valid) vld_cycles++;
      if (bus.sample_valid && bus.sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0h required=none", cur);
        end else begin
          chk("word", 32'(cur), 32'(exp_q.pop_front()));
        end
        got_q.push_back(cur);
      end
      if (bus.short_word) begin
        short_seen++;
        chk("short_one_cycle", 32'(prev_short), 0);
        if (chk_align) chk("short_with_write", 32'(bus.sample_valid), 1);
      end
      if (bus.overrun) begin
        ovr_seen++;
        chk("overrun_one_cycle", 32'(prev_ovr), 0);
      end
      prev_stall = bus.sample_valid && !bus.sample_ready;
      prev_word  = cur;
      prev_short = bus.short_word;
      prev_ovr   = bus.overrun;
    end else begin
      prev_stall = 0;
      prev_short = 0;
      prev_ovr   = 0;
    end
  end

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    exp_short = 0; exp_ovr = 0; short_seen = 0; ovr_seen = 0; vld_cycles = 0;
  endtask

  task automatic start_scn(input int pmin, input int pmax, input int rmode);
    mon_en = 0;
    @(negedge clk);
    #2;
    rst = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; carry = 1'b0;
    ready_mode = rmode; ph_min = pmin; ph_max = pmax; chk_align = 0;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1;
  endtask

  task automatic mid_reset();
    chk("pre_rst_valid", 32'(bus.sample_valid), 1);
    #3;
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.sample_valid), 0);
    chk("rst_async_data", 32'({bus.sample_right, bus.sample_data}), 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1;
  endtask

  // One half-frame of n sck periods on channel ch; slot 0 carries the previous word's last bit.
  task automatic send_hf(input logic ch, input int n, input logic [DATA_W-1:0] w,
                         input bit ex, input bit drop, input int rst_slot, input bit pulse);
    if (ex) begin
      if (drop) exp_ovr++;
      else begin
        exp_q.push_back({ch, keep_msbs(w, n)});
        if (n < DATA_W) exp_short++;
      end
    end
    for (int s = 0; s < n; s++) begin
      sck = 1'b0;
      ws  = ch;
      sd  = (s == 0) ? carry : tx_bit(w, s - 1);
      repeat ($urandom_range(ph_max, ph_min)) @(negedge clk);
      sck = 1'b1;
      if (s == 0 && pulse) begin
        fork
          begin
            @(posedge clk);
            @(posedge clk);
            #4 ready_mode = 1;
            @(posedge clk);
            #4 ready_mode = 0;
          end
        join_none
      end
      if (s == rst_slot) mid_reset();
      repeat ($urandom_range(ph_max, ph_min)) @(negedge clk);
    end
    carry = tx_bit(w, n - 1);
  endtask

  task automatic end_scn(input string nm);
    ready_mode = 1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk({nm, "_drained"}, 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
    chk({nm, "_short_count"}, 32'(short_seen), 32'(exp_short));
    chk({nm, "_overrun_count"}, 32'(ovr_seen), 32'(exp_ovr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; carry = 1'b0;

    // Reset state
    start_scn(2, 2, 1);
    chk("rst_valid", 32'(bus.sample_valid), 0);
    chk("rst_data", 32'(bus.sample_data), 0);
    chk("rst_right", 32'(bus.sample_right), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_short", 32'(bus.short_word), 0);

    // Full-length words, extreme values
    send_hf(1'b1, 24, 23'h155555, 0, 0, -1, 0);
    send_hf(1'b0, 24, 23'h3FFFFF, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h400001, 1, 0, -1, 0);
    send_hf(1'b0, 24, 23'h2AAAAA, 0, 0, -1, 0);
    end_scn("full");
    chk("full_count", 32'(got_q.size()), 2);
    chk("full_w0", 32'(got_q[0]), 32'h03FFFFF);
    chk("full_w1", 32'(got_q[1]), 32'h0C00001);
    chk("full_valid_cycles", 32'(vld_cycles), 2);

    // 16-bit half-frames: left-justified, short_word
    start_scn(2, 2, 1);
    chk_align = 1;
    send_hf(1'b1, 16, 23'h7FFFFF, 0, 0, -1, 0);
    send_hf(1'b0, 16, 23'h52D280, 1, 0, -1, 0);
    send_hf(1'b1, 16, 23'h091A00, 1, 0, -1, 0);
    send_hf(1'b0, 16, 23'h000000, 0, 0, -1, 0);
    end_scn("short");
    chk("short_w0", 32'(got_q[0]), 32'h052D280);
    chk("short_w1", 32'(got_q[1]), 32'h0891A00);

    // Consumer stalled over three words
    start_scn(2, 2, 0);
    send_hf(1'b1, 24, 23'h000000, 0, 0, -1, 0);
    send_hf(1'b0, 24, 23'h123456, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h654321, 1, 0, -1, 0);
    send_hf(1'b0, 24, 23'h0ABCDE, 1, 1, -1, 0);
    send_hf(1'b1, 24, 23'h3C3C3C, 1, 0, -1, 0);
    ready_mode = 1;
    send_hf(1'b0, 24, 23'h000000, 0, 0, -1, 0);
    end_scn("ovr");
    chk("ovr_w0", 32'(got_q[0]), 32'h0123456);
    chk("ovr_w1", 32'(got_q[1]), 32'h0E54321);
    chk("ovr_w2", 32'(got_q[2]), 32'h0BC3C3C);

    // Full buffer with a read in the write cycle
    start_scn(2, 2, 0);
    send_hf(1'b1, 24, 23'h000000, 0, 0, -1, 0);
    send_hf(1'b0, 24, 23'h111111, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h222222, 1, 0, -1, 0);
    send_hf(1'b0, 24, 23'h333333, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h444444, 1, 0, -1, 1);
    ready_mode = 1;
    send_hf(1'b0, 24, 23'h000000, 0, 0, -1, 0);
    end_scn("coinc");
    chk("coinc_count", 32'(got_q.size()), 4);
    chk("coinc_w2", 32'(got_q[2]), 32'h0333333);

    // Reset mid-word with one word buffered
    start_scn(2, 2, 0);
    send_hf(1'b1, 24, 23'h000000, 0, 0, -1, 0);
    send_hf(1'b0, 24, 23'h0F0F0F, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h707070, 0, 0, 10, 0);
    ready_mode = 1;
    send_hf(1'b0, 24, 23'h1A2B3C, 1, 0, -1, 0);
    send_hf(1'b1, 24, 23'h4D5E6F, 1, 0, -1, 0);
    send_hf(1'b0, 24, 23'h000000, 0, 0, -1, 0);
    end_scn("rst");
    chk("rst_first_word", 32'(got_q[0]), 32'h01A2B3C);

    // 4:1 oversampling with jittered sck phases and mixed word lengths
    start_scn(2, 3, 2);
    send_hf(1'b1, 24, 23'h000000, 0, 0, -1, 0);
    for (int k = 0; k < 12; k++) begin
      rw = DATA_W'($urandom());
      rn = 20 + $urandom_range(0, 6);
      send_hf(1'(k % 2), rn, rw, 1, 0, -1, 0);
    end
    send_hf(1'b0, 24, 23'h000000, 0, 0, -1, 0);
    end_scn("jitter");
    chk("jitter_count", 32'(got_q.size()), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
